// File: rtl/memory_stage.sv
// MEM pipeline stage: issues variable-latency data-memory accesses over a
// request/done handshake, stalls upstream while unresolved, owns the MEM/WB register.
module memory_stage #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALUO_EXMEM,
    input  logic [15:0] Rd2_EXMEM,
    input  logic [2:0]  WrR_EXMEM,
    input  logic        RegWrite_EXMEM,
    input  logic        MemtoReg_EXMEM,
    input  logic        MemRead_EXMEM,
    input  logic        MemWrite_EXMEM,
    input  logic        halt_EXMEM,
    input  logic        Dump_EXMEM,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        stall_MEM,
    output logic [15:0] MemData_MEMWB,
    output logic [15:0] ALUO_MEMWB,
    output logic [2:0]  WrR_MEMWB,
    output logic        RegWrite_MEMWB,
    output logic        MemtoReg_MEMWB,
    output logic        halt_MEMWB,
    output logic        Dump_MEMWB,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        acc, bad, rd_cmpl;

    logic [15:0] memdata_q, aluo_q;
    logic [2:0]  wrr_q;
    logic        regwrite_q, memtoreg_q, halt_q, dump_q;

    assign acc       = MemRead_EXMEM | MemWrite_EXMEM;
    assign bad       = acc & (ALUO_EXMEM[0] | (MemRead_EXMEM & MemWrite_EXMEM));
    assign mem_addr  = ALUO_EXMEM;
    assign mem_wdata = Rd2_EXMEM;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_MEM = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bad) begin
                    stall_MEM = 1'b1;
                    state_d   = ERR;
                end else if (acc) begin
                    mem_rd = MemRead_EXMEM;
                    mem_wr = MemWrite_EXMEM;
                    if (!mem_done) begin
                        stall_MEM = 1'b1;
                        state_d   = BUSY;
                        cnt_d     = 8'd1;
                    end
                end
            end
            BUSY: begin
                // EX/MEM is frozen by the stall, so the request stays stable here
                mem_rd = MemRead_EXMEM;
                mem_wr = MemWrite_EXMEM;
                if (mem_done) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    stall_MEM = 1'b1;
                    if (cnt_q == 8'(MEM_TIMEOUT)) begin
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                stall_MEM = 1'b1;
            end
        endcase
    end

    assign rd_cmpl = !stall_MEM & MemRead_EXMEM & mem_done;
    assign err     = (state_q == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB boundary: a stall inserts a bubble but keeps the data fields
    always_ff @(posedge clk) begin
        if (rst) begin
            memdata_q  <= 16'd0;
            aluo_q     <= 16'd0;
            wrr_q      <= 3'd0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            halt_q     <= 1'b0;
            dump_q     <= 1'b0;
        end else begin
            if (!stall_MEM) begin
                aluo_q     <= ALUO_EXMEM;
                wrr_q      <= WrR_EXMEM;
                regwrite_q <= RegWrite_EXMEM;
                memtoreg_q <= MemtoReg_EXMEM;
                halt_q     <= halt_EXMEM;
                dump_q     <= Dump_EXMEM;
            end else begin
                regwrite_q <= 1'b0;
                halt_q     <= 1'b0;
                dump_q     <= 1'b0;
            end
            if (rd_cmpl) begin
                memdata_q <= mem_rdata;
            end
        end
    end

    assign MemData_MEMWB  = memdata_q;
    assign ALUO_MEMWB     = aluo_q;
    assign WrR_MEMWB      = wrr_q;
    assign RegWrite_MEMWB = regwrite_q;
    assign MemtoReg_MEMWB = memtoreg_q;
    assign halt_MEMWB     = halt_q;
    assign Dump_MEMWB     = dump_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver issues instructions with chosen
// memory latencies, a monitor pops expected MEM/WB contents on every non-stalled edge.
module tb_memory_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ALUO_EXMEM, Rd2_EXMEM, mem_rdata;
    logic [2:0]  WrR_EXMEM;
    logic        RegWrite_EXMEM, MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM;
    logic        halt_EXMEM, Dump_EXMEM, mem_done;
    logic [15:0] mem_addr, mem_wdata, MemData_MEMWB, ALUO_MEMWB;
    logic        mem_rd, mem_wr, stall_MEM, err;
    logic [2:0]  WrR_MEMWB;
    logic        RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB, Dump_MEMWB;

    memory_stage #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .WrR_EXMEM(WrR_EXMEM),
        .RegWrite_EXMEM(RegWrite_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM),
        .MemRead_EXMEM(MemRead_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
        .halt_EXMEM(halt_EXMEM), .Dump_EXMEM(Dump_EXMEM),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .stall_MEM(stall_MEM), .MemData_MEMWB(MemData_MEMWB), .ALUO_MEMWB(ALUO_MEMWB),
        .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
        .MemtoReg_MEMWB(MemtoReg_MEMWB), .halt_MEMWB(halt_MEMWB),
        .Dump_MEMWB(Dump_MEMWB), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] md;
        logic [2:0]  wrr;
        logic        rw, m2r, halt, dump;
        int          stalls;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        sb_on    = 1'b0;
    logic [15:0] md_model = 16'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ALUO_EXMEM = 16'd0; Rd2_EXMEM = 16'd0; WrR_EXMEM = 3'd0;
        RegWrite_EXMEM = 1'b0; MemtoReg_EXMEM = 1'b0;
        MemRead_EXMEM = 1'b0; MemWrite_EXMEM = 1'b0;
        halt_EXMEM = 1'b0; Dump_EXMEM = 1'b0;
        mem_done = 1'b0; mem_rdata = 16'd0;
    endtask

    // Called at a negedge; holds the instruction for lat+1 cycles, memory answers on the last.
    task automatic issue(input logic [15:0] alu, input logic [15:0] rd2, input logic [2:0] wrr,
                         input logic rw, input logic m2r, input logic rd, input logic wr,
                         input logic halt, input logic dump, input int lat,
                         input logic [15:0] rdata);
        exp_t e;
        logic acc;
        acc = rd | wr;
        if (rd) md_model = rdata;
        e.alu = alu; e.md = md_model; e.wrr = wrr; e.rw = rw; e.m2r = m2r;
        e.halt = halt; e.dump = dump; e.stalls = acc ? lat : 0;
        sbq.push_back(e);
        ALUO_EXMEM = alu; Rd2_EXMEM = rd2; WrR_EXMEM = wrr; RegWrite_EXMEM = rw;
        MemtoReg_EXMEM = m2r; MemRead_EXMEM = rd; MemWrite_EXMEM = wr;
        halt_EXMEM = halt; Dump_EXMEM = dump;
        for (int k = 0; k <= e.stalls; k++) begin
            if (acc) begin
                mem_done  = (k == lat);
                mem_rdata = (k == lat) ? rdata : 16'($urandom);
            end else begin
                mem_done  = 1'($urandom);
                mem_rdata = 16'($urandom);
            end
            #1;
            chk("mem_rd", {31'd0, mem_rd}, {31'd0, rd});
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, wr});
            chk("stall_MEM", {31'd0, stall_MEM}, {31'd0, acc && (k < lat)});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, alu});
            chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, rd2});
            @(negedge clk);
        end
    endtask

    // Monitor: stall sampled mid-cycle, MEM/WB checked just after the following edge
    initial begin
        logic st_s, sb_s;
        int   nstall;
        exp_t e;
        nstall = 0;
        forever begin
            @(negedge clk); #2;
            st_s = stall_MEM;
            sb_s = sb_on;
            @(posedge clk); #1;
            if (sb_s) begin
                if (st_s) begin
                    nstall++;
                    chk("bubble_rw", {31'd0, RegWrite_MEMWB}, 32'd0);
                    chk("bubble_halt", {31'd0, halt_MEMWB}, 32'd0);
                    chk("bubble_dump", {31'd0, Dump_MEMWB}, 32'd0);
                end else if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("ALUO_MEMWB", {16'd0, ALUO_MEMWB}, {16'd0, e.alu});
                    chk("MemData_MEMWB", {16'd0, MemData_MEMWB}, {16'd0, e.md});
                    chk("WrR_MEMWB", {29'd0, WrR_MEMWB}, {29'd0, e.wrr});
                    chk("RegWrite_MEMWB", {31'd0, RegWrite_MEMWB}, {31'd0, e.rw});
                    chk("MemtoReg_MEMWB", {31'd0, MemtoReg_MEMWB}, {31'd0, e.m2r});
                    chk("halt_MEMWB", {31'd0, halt_MEMWB}, {31'd0, e.halt});
                    chk("Dump_MEMWB", {31'd0, Dump_MEMWB}, {31'd0, e.dump});
                    chk("stall_cycles", nstall, e.stalls);
                    nstall = 0;
                end
            end else begin
                nstall = 0;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_MEM}, 32'd0);
        chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, "_memwb"},
            {ALUO_MEMWB, 16'd0} | {16'd0, MemData_MEMWB} |
            {25'd0, WrR_MEMWB, RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB, Dump_MEMWB},
            32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        md_model = 16'd0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, lat;
        logic [15:0] addr;
        rst = 1'b1;
        idle_inputs();
        do_reset();
        check_reset_state("reset");

        // Directed: plain ALU op, zero-wait load, 3-cycle load, then random traffic
        @(negedge clk);
        sb_on = 1'b1;
        issue(16'h1234, 16'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
        issue(16'h0040, 16'h0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'hBEEF);
        issue(16'h0080, 16'h0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 16'hCAFE);
        issue(16'h0082, 16'h5A5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, TO, 16'h0);
        for (int i = 0; i < 250; i++) begin
            kind = int'($urandom_range(0, 2));
            lat  = int'($urandom_range(0, TO));
            addr = 16'($urandom) & 16'hFFFE;
            issue(kind == 0 ? 16'($urandom) : addr, 16'($urandom), 3'($urandom),
                  1'($urandom), kind == 1, kind == 1, kind == 2,
                  1'($urandom), 1'($urandom), lat, 16'($urandom));
        end
        sb_on = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);

        // Reset while BUSY abandons the access
        ALUO_EXMEM = 16'h0200; MemRead_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        md_model = 16'd0;
        #1;
        check_reset_state("rst_busy");

        // Timeout: no mem_done ever
        @(negedge clk);
        ALUO_EXMEM = 16'h0100; MemRead_EXMEM = 1'b1;
        #1;
        chk("to_rd_idle", {31'd0, mem_rd}, 32'd1);
        chk("to_stall_idle", {31'd0, stall_MEM}, 32'd1);
        for (int b = 1; b <= TO; b++) begin
            @(negedge clk); #1;
            chk("to_rd_busy", {31'd0, mem_rd}, 32'd1);
            chk("to_err_busy", {31'd0, err}, 32'd0);
            chk("to_stall_busy", {31'd0, stall_MEM}, 32'd1);
        end
        @(negedge clk); #1;
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rd_err", {31'd0, mem_rd}, 32'd0);
        chk("to_stall_err", {31'd0, stall_MEM}, 32'd1);
        do_reset();
        check_reset_state("rst_err");

        // Misaligned store: no request, sticky error
        @(negedge clk);
        ALUO_EXMEM = 16'h0041; MemWrite_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
        #1;
        chk("mis_wr", {31'd0, mem_wr}, 32'd0);
        chk("mis_stall", {31'd0, stall_MEM}, 32'd1);
        chk("mis_err0", {31'd0, err}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                idle_inputs();
                mem_done = 1'b1;
            end
            #1;
            chk("mis_err", {31'd0, err}, 32'd1);
            chk("mis_stall_hold", {31'd0, stall_MEM}, 32'd1);
            chk("mis_wr_hold", {31'd0, mem_wr}, 32'd0);
            chk("mis_bubble", {31'd0, RegWrite_MEMWB}, 32'd0);
        end
        do_reset();
        check_reset_state("rst_mis");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
